ip_bus_arbiter: RTL and testbench
=================================

// Module: ip_bus_arbiter
// PURPOSE
//  Two-requester arbiter in front of the hard-IP wrapper bus (I2C/SPI/PWM, iomem 0x05xx_xxxx window).
//  Port m0 = CPU iomem path; port m1 = autonomous hardware sequencer (e.g. sensor poller).
//  Round-robin grant, one transaction in flight, registered slave-side request; optional hang watchdog.
// PARAMETERS
//  ADDR_W          24   address width forwarded to the IP wrapper
//  DATA_W          32   data width; strobe width = DATA_W/8
//  TIMEOUT_CYCLES  256  watchdog limit in clk cycles (used only with IP_BUS_TIMEOUT_EN)
// PORTS
//  clk          in   1         system clock
//  resetn       in   1         synchronous, active-low reset
//  m0_valid     in   1         requester 0 transaction request
//  m0_ready     out  1         requester 0 completion pulse
//  m0_addr      in   ADDR_W    requester 0 address
//  m0_wdata     in   DATA_W    requester 0 write data
//  m0_wstrb     in   DATA_W/8  requester 0 byte strobes (0 = read)
//  m0_rdata     out  DATA_W    requester 0 read data, valid while m0_ready=1
//  m1_*         same as m0_*, requester 1
//  s_valid      out  1         request to IP wrapper
//  s_ready      in   1         IP wrapper completion
//  s_addr       out  ADDR_W    registered address
//  s_wdata      out  DATA_W    registered write data
//  s_wstrb      out  DATA_W/8  registered strobes
//  s_rdata      in   DATA_W    IP wrapper read data, sampled when s_valid&s_ready
//  grant        out  2         one-hot owner of current transaction (00 = idle)
//  err_clr      in   1         clears timeout_err
//  timeout_err  out  1         sticky watchdog flag
// BEHAVIOUR
//  Reset: s_valid=0, m0_ready=m1_ready=0, m*_rdata=0, s_addr/s_wdata/s_wstrb=0, grant=00,
//   timeout_err=0, state=IDLE, rr pointer=m0 preferred. Reset mid-transaction aborts it; no ready pulse.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: if only one mX_valid, grant it; if both, grant the one NOT granted last (rr pointer);
//   latch its addr/wdata/wstrb into s_*, set grant, s_valid=1 next cycle, go BUSY.
//  BUSY: s_valid held, s_* stable. On clk edge with s_ready=1: s_valid<=0, owner mX_rdata<=s_rdata,
//   mX_ready<=1 (exactly one cycle), rr pointer<=other port, go DONE.
//  DONE: ready pulse visible; grant cleared; no new grant this cycle (lets requester drop valid).
//   Next cycle IDLE. Non-owner m*_ready always 0; m*_rdata held between transactions.
//  Latency: valid seen cycle N -> s_valid at N+1 -> earliest mX_ready at N+2 (s_ready at N+1).
//  Requesters hold valid/addr/wdata/wstrb until ready; a valid dropped mid-BUSY is ignored,
//   transaction still completes and ready still pulses.
//  Waiting requester stays pending indefinitely; no starvation: at most one other transaction first.
//  s_ready while s_valid=0 is ignored.
//  err_clr and a new timeout in same cycle: timeout_err set wins.
// CONFIGURATION
//  IP_BUS_TIMEOUT_EN defined: 16-bit counter clears on entering BUSY, increments each BUSY cycle;
//   when it reaches TIMEOUT_CYCLES-1 without s_ready: s_valid<=0, owner ready pulses with
//   rdata=all-ones, timeout_err<=1, go DONE. s_ready in that same cycle takes precedence (normal completion).
//  Not defined: no counter, BUSY waits forever, timeout_err tied 0, err_clr unused.
// TESTING
//  m0 read addr 0x000010, s_ready 1 cycle after s_valid, s_rdata=0x1234_5678 -> m0_ready 1 cycle, m0_rdata=0x1234_5678, grant=01.
//  m0,m1 valid same cycle from reset -> m0 first, m1 second; repeat both -> order m0,m1,m0,m1.
//  m1 write wdata=0xA5, wstrb=0001, s_ready delayed 5 cycles -> s_addr/s_wdata/s_wstrb stable all 5 cycles, single m1_ready.
//  resetn low while BUSY -> next cycle s_valid=0, grant=00, no m*_ready; post-reset m0 preferred.
//  IP_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, s_ready never -> ready after 8 BUSY cycles, rdata=0xFFFF_FFFF, timeout_err=1; err_clr -> 0.
//  s_ready pulsed while IDLE -> no m*_ready, state unchanged.

Source files
------------

// File: rtl/ip_bus_arbiter.sv
// ip_bus_arbiter: two-requester round-robin arbiter in front of the hard-IP
// wrapper bus. m0 = CPU iomem path, m1 = autonomous hardware sequencer.
// One transaction in flight; the slave-side request is registered.
// Optional hang watchdog enabled by defining IP_BUS_TIMEOUT_EN.
module ip_bus_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  s_valid,
    input  logic                  s_ready,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    input  logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            grant,
    input  logic                  err_clr,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, state_n;
    logic                owner;       // 0 = m0, 1 = m1
    logic                rr_pref;     // port that wins when both request
    logic                pick_m1;
    logic                grant_fire;
    logic                complete;
    logic                tmo_hit;
    logic [DATA_W-1:0]   done_data;

    assign pick_m1   = m1_valid & (~m0_valid | rr_pref);
    assign done_data = tmo_hit ? '1 : s_rdata;

`ifdef IP_BUS_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Watchdog: counts BUSY cycles of the current transaction, zero otherwise
    always_ff @(posedge clk) begin
        if (!resetn)             tmo_cnt <= '0;
        else if (state != BUSY)  tmo_cnt <= '0;
        else                     tmo_cnt <= tmo_cnt + 16'd1;
    end

    // A real s_ready in the limit cycle still counts as normal completion
    assign tmo_hit = (state == BUSY) && !s_ready &&
                     (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Sticky error flag; a new timeout beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!resetn)       timeout_err <= 1'b0;
        else if (tmo_hit)  timeout_err <= 1'b1;
        else if (err_clr)  timeout_err <= 1'b0;
    end
`else
    localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign tmo_hit        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    // Next state; DONE always returns to IDLE so the owner can drop valid
    always_comb begin
        state_n    = state;
        grant_fire = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: if (m0_valid || m1_valid) begin
                state_n    = BUSY;
                grant_fire = 1'b1;
            end
            BUSY: if (s_ready || tmo_hit) begin
                state_n  = DONE;
                complete = 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Capture the winner's request into the slave-side registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s_valid <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wstrb <= '0;
            grant   <= 2'b00;
            owner   <= 1'b0;
        end else if (grant_fire) begin
            s_valid <= 1'b1;
            s_addr  <= pick_m1 ? m1_addr  : m0_addr;
            s_wdata <= pick_m1 ? m1_wdata : m0_wdata;
            s_wstrb <= pick_m1 ? m1_wstrb : m0_wstrb;
            grant   <= pick_m1 ? 2'b10 : 2'b01;
            owner   <= pick_m1;
        end else if (complete) begin
            s_valid <= 1'b0;
            grant   <= 2'b00;
        end
    end

    // Completion: one-cycle ready to the owner, read data, rotate preference
    always_ff @(posedge clk) begin
        if (!resetn) begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            rr_pref  <= 1'b0;
        end else begin
            m0_ready <= complete & ~owner;
            m1_ready <= complete &  owner;
            if (complete) begin
                rr_pref <= ~owner;
                if (owner) m1_rdata <= done_data;
                else       m0_rdata <= done_data;
            end
        end
    end

endmodule

// File: tb/tb_ip_bus_arbiter.sv
// tb_ip_bus_arbiter: table-driven plus randomized checking of ip_bus_arbiter
// against a transaction-level reference model (pending set + last-served port).
`timescale 1ns/1ps
module tb_ip_bus_arbiter;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          m0_valid = 1'b0, m1_valid = 1'b0;
    logic          m0_ready, m1_ready;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic [SW-1:0] m0_wstrb = '0, m1_wstrb = '0;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          s_valid;
    logic          s_ready = 1'b0;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic [DW-1:0] s_rdata = '0;
    logic [1:0]    grant;
    logic          err_clr = 1'b0;
    logic          timeout_err;

    always #5 clk = ~clk;

    ip_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .grant(grant), .err_clr(err_clr), .timeout_err(timeout_err)
    );

    typedef struct {
        bit            rst;
        logic [1:0]    v;       // bit p = port p requests
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [SW-1:0] ws;
        int            dly;
        logic [DW-1:0] rd;
        int            first;   // port expected to complete first
    } vec_t;

    vec_t tbl [8];

    int vectors = 0;
    int miscompares = 0;

    // Requester intent
    logic          rq_v [2];
    logic [AW-1:0] rq_a [2];
    logic [DW-1:0] rq_d [2];
    logic [SW-1:0] rq_s [2];

    // Reference model
    int            owner_m = -1;
    int            t = 0;
    int            lat = 0;
    int            last = 1;
    bit            cool = 0;
    bit            err_m = 0;
    bit            tmo_exp = 0;
    logic [DW-1:0] exp_rd = '0;
    logic [DW-1:0] held [2];
    logic [AW-1:0] oa;
    logic [DW-1:0] od;
    logic [SW-1:0] os;
    int            cur_delay = 0;
    logic [DW-1:0] cur_rdata = '0;
    bit            rnd_mode = 0;
    bit            noise = 0;
    int            done_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic v0, input logic v1, input int last_w);
        if (v0 && v1) return (last_w == 0) ? 1 : 0;
        return v1 ? 1 : 0;
    endfunction

    task automatic apply();
        m0_valid = rq_v[0]; m0_addr = rq_a[0]; m0_wdata = rq_d[0]; m0_wstrb = rq_s[0];
        m1_valid = rq_v[1]; m1_addr = rq_a[1]; m1_wdata = rq_d[1]; m1_wstrb = rq_s[1];
    endtask

    task automatic model_reset();
        owner_m = -1; t = 0; last = 1; cool = 0; err_m = 0;
        held[0] = '0; held[1] = '0;
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0; rq_v[0] = 1'b0; rq_v[1] = 1'b0;
        s_ready = 1'b0; err_clr = 1'b0;
        apply();
        repeat (n) begin
            @(posedge clk); #1;
            chk("rst_ctl", {s_valid, grant, m1_ready, m0_ready, timeout_err}, 0);
            chk("rst_s_addr", s_addr, 0);
            chk("rst_s_wdata", s_wdata, 0);
            chk("rst_s_wstrb", s_wstrb, 0);
            chk("rst_m0_rdata", m0_rdata, 0);
            chk("rst_m1_rdata", m1_rdata, 0);
        end
        resetn = 1'b1;
        model_reset();
    endtask

    // One clock: drive, sample after the edge, compare against the model, respond
    task automatic cycle();
        logic [1:0] rdy;
        bit         done_now [2];
        bit         tmo_now;
        int         w;
        done_now[0] = 0; done_now[1] = 0; tmo_now = 0;
        apply();
        @(posedge clk); #1;
        rdy = {m1_ready, m0_ready};
        if (owner_m >= 0) begin
            t++;
            if (t == lat) begin
                chk("ready_pulse", rdy, 2'b01 << owner_m);
                chk("rdata", (owner_m == 1) ? m1_rdata : m0_rdata, exp_rd);
                chk("grant_done", grant, 0);
                chk("s_valid_done", s_valid, 0);
                held[owner_m] = exp_rd;
                tmo_now = tmo_exp;
                last = owner_m;
                rq_v[owner_m] = 1'b0;
                done_now[owner_m] = 1;
                done_q.push_back(owner_m);
                owner_m = -1;
                cool = 1;
            end else begin
                chk("ready_busy", rdy, 0);
                chk("s_valid_busy", s_valid, 1);
                chk("grant_busy", grant, 2'b01 << owner_m);
                chk("s_addr_hold", s_addr, oa);
                chk("s_wdata_hold", s_wdata, od);
                chk("s_wstrb_hold", s_wstrb, os);
            end
        end else if (cool) begin
            chk("done_gap", {s_valid, grant, rdy}, 0);
            cool = 0;
        end else if (rq_v[0] || rq_v[1]) begin
            w = pick(rq_v[0], rq_v[1], last);
            oa = rq_a[w]; od = rq_d[w]; os = rq_s[w];
            chk("s_valid_rise", s_valid, 1);
            chk("grant", grant, 2'b01 << w);
            chk("ready_rise", rdy, 0);
            chk("s_addr", s_addr, oa);
            chk("s_wdata", s_wdata, od);
            chk("s_wstrb", s_wstrb, os);
            if (rnd_mode) begin
                cur_delay = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 4));
                cur_rdata = $urandom;
            end
`ifdef IP_BUS_TIMEOUT_EN
            tmo_exp = (cur_delay > TO - 1);
            lat = tmo_exp ? TO : cur_delay + 1;
`else
            tmo_exp = 0;
            lat = cur_delay + 1;
`endif
            exp_rd = tmo_exp ? '1 : cur_rdata;
            owner_m = w;
            t = 0;
        end else begin
            chk("idle", {s_valid, grant, rdy}, 0);
        end
        if (tmo_now) err_m = 1;
        else if (err_clr) err_m = 0;
        chk("timeout_err", timeout_err, err_m);
        chk("m0_rdata_hold", m0_rdata, held[0]);
        chk("m1_rdata_hold", m1_rdata, held[1]);
        // slave responder
        if (owner_m >= 0 && s_valid) begin
            s_ready = (t == cur_delay);
            s_rdata = s_ready ? cur_rdata : DW'($urandom);
        end else begin
            s_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            s_rdata = $urandom;
        end
        if (rnd_mode) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq_v[p] && !done_now[p] && $urandom_range(0, 2) == 0) begin
                    rq_v[p] = 1'b1;
                    rq_a[p] = AW'($urandom);
                    rq_d[p] = $urandom;
                    rq_s[p] = ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0;
                end
            end
        end
    endtask

    task automatic run_idle(input int maxc);
        int n;
        n = 0;
        while ((owner_m >= 0 || rq_v[0] || rq_v[1] || cool) && n < maxc) begin
            cycle();
            n++;
        end
        if (n >= maxc) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_bound: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic request(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
        rq_v[p] = 1'b1; rq_a[p] = a; rq_d[p] = d; rq_s[p] = s;
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            rq_v[p] = 1'b0; rq_a[p] = '0; rq_d[p] = '0; rq_s[p] = '0; held[p] = '0;
        end
        tbl[0] = '{0, 2'b01, 24'h000010, 32'h0,  4'h0, 0, 32'h1234_5678, 0};
        tbl[1] = '{1, 2'b11, 24'h000020, 32'h11, 4'hF, 1, 32'hCAFE_0001, 0};
        tbl[2] = '{0, 2'b11, 24'h000030, 32'h22, 4'h3, 0, 32'hBEEF_0002, 0};
        tbl[3] = '{0, 2'b10, 24'h000040, 32'hA5, 4'h1, 5, 32'h0000_0000, 1};
        tbl[4] = '{0, 2'b11, 24'h000050, 32'h33, 4'h0, 2, 32'h5555_AAAA, 0};
        tbl[5] = '{0, 2'b01, 24'h000060, 32'h44, 4'h0, 3, 32'h0F0F_F0F0, 0};
        tbl[6] = '{0, 2'b11, 24'h000070, 32'h55, 4'hC, 0, 32'h8000_0001, 1};
        tbl[7] = '{0, 2'b01, 24'h000080, 32'h0,  4'h0, 0, 32'h7777_7777, 0};

        do_reset(3);

        // Table: each row issued, drained, and its completion order checked
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset(2);
            cur_delay = tbl[i].dly;
            cur_rdata = tbl[i].rd;
            done_q.delete();
            for (int p = 0; p < 2; p++)
                if (tbl[i].v[p])
                    request(p, tbl[i].addr | ((p == 1) ? 24'h000100 : 24'h0),
                            tbl[i].wd ^ DW'(p), tbl[i].ws);
            run_idle(100);
            chk("tbl_count", done_q.size(), $countones(tbl[i].v));
            if (done_q.size() > 0) chk("tbl_first", done_q[0], tbl[i].first);
        end

        // Reset while BUSY (preference currently m1): aborts, m0 preferred after
        cur_delay = 1000;
        request(1, 24'h05_0100, 32'hDEAD_BEEF, 4'hF);
        repeat (3) cycle();
        chk("pre_reset_busy", s_valid, 1);
        do_reset(1);
        repeat (3) cycle();
        cur_delay = 0; cur_rdata = 32'h0000_1111;
        done_q.delete();
        request(0, 24'h000200, 32'h1, 4'h0);
        request(1, 24'h000300, 32'h2, 4'h0);
        run_idle(50);
        chk("post_reset_count", done_q.size(), 2);
        if (done_q.size() > 0) chk("post_reset_first", done_q[0], 0);

        // Owner drops valid mid-BUSY: transaction still completes
        cur_delay = 3; cur_rdata = 32'h0BAD_F00D;
        done_q.delete();
        request(0, 24'h000400, 32'h0, 4'h0);
        cycle();
        rq_v[0] = 1'b0;
        run_idle(20);
        chk("drop_mid_busy_done", done_q.size(), 1);

        // s_ready noise while idle must not produce any completion
        noise = 1;
        repeat (8) cycle();
        noise = 0;

`ifdef IP_BUS_TIMEOUT_EN
        // Hang: slave never answers
        cur_delay = 1000; cur_rdata = 32'h1;
        request(0, 24'h000500, 32'h0, 4'h0);
        run_idle(40);
        err_clr = 1'b1; cycle(); err_clr = 1'b0; cycle();
        // s_ready in the limit cycle wins over the watchdog
        cur_delay = TO - 1; cur_rdata = 32'h2468_ACE0;
        request(1, 24'h000600, 32'h0, 4'h0);
        run_idle(40);
        // clear held high across a new timeout: the set wins
        err_clr = 1'b1;
        cur_delay = 1000;
        request(0, 24'h000700, 32'h0, 4'h0);
        run_idle(40);
        err_clr = 1'b0;
        cycle();
`else
        // No watchdog: a long stall simply waits
        cur_delay = 40; cur_rdata = 32'h1357_9BDF;
        request(0, 24'h000500, 32'h0, 4'h0);
        run_idle(100);
`endif

        // Randomized traffic against the model
        rnd_mode = 1; noise = 1;
        repeat (3000) cycle();
        rnd_mode = 0; noise = 0;
        run_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
